l2_read_arbiter: RTL and testbench
==================================

// Module: l2_read_arbiter
//
// PURPOSE
// - Shares one L2 line-read port among NUM_REQ L1 miss engines (I-cache port 0, D-cache port 1).
// - Each requester uses the L1 miss protocol: assert read, hold address, wait for ack with a 512-bit line.
// - Sits between the L1 caches and L2; grants round-robin; one outstanding L2 read at a time.
//
// PARAMETERS
// - NUM_REQ     2   number of requesters (2..8)
// - ADDR_WIDTH  26  line address width ({tag,set})
// - REQ_IDX_W   1   width of owner index, $clog2(NUM_REQ)
//
// PORTS
// - clk           in   1                  clock
// - reset_n       in   1                  async reset, active low
// - req_read_i    in   NUM_REQ            per-requester read request (held until its ack)
// - req_addr_i    in   NUM_REQ*ADDR_WIDTH flattened line addresses; port n at [n*ADDR_WIDTH +: ADDR_WIDTH]
// - req_ack_o     out  NUM_REQ            one-hot completion pulse to the owner
// - req_data_o    out  512                returned line, broadcast to all requesters
// - l2_read_o     out  1                  read request to L2
// - l2_addr_o     out  ADDR_WIDTH         line address to L2 (registered)
// - l2_ack_i      in   1                  L2 completion; valid only while l2_read_o=1
// - l2_data_i     in   512                L2 line data, valid with l2_ack_i
// - owner_o       out  REQ_IDX_W          current or last granted requester
//
// BEHAVIOUR
// - Reset: state=IDLE, l2_read_o=0, l2_addr_o=0, req_ack_o=0, owner_o=0, rr_ptr=0.
// - States:
//   - IDLE: if any req_read_i, pick the first set bit at or after rr_ptr (wrapping).
//     On the next edge: latch owner_o and l2_addr_o from the winner, set l2_read_o=1, go BUSY.
//   - BUSY: l2_read_o=1; l2_addr_o stays frozen even if the owner's req_addr_i changes.
// - BUSY with l2_ack_i=1 (combinational, same cycle):
//   - req_ack_o[owner]=1.
//   - req_data_o=l2_data_i (req_data_o always follows l2_data_i).
//   - Next edge: l2_read_o=0, rr_ptr=owner+1 (wrap at NUM_REQ-1 -> 0), state IDLE.
// - Latency: req asserted in IDLE -> l2_read_o high 1 cycle later.
//   - Ack cycle -> earliest next grant 1 cycle later (1 idle bubble).
//   - The bubble guarantees the completed requester's req_read_i has already dropped.
//     It can never be re-granted on a stale request.
// - req_ack_o is at most one-hot, never set outside BUSY. l2_ack_i in IDLE is ignored.
// - Owner deasserts req_read_i while BUSY (protocol error): the L2 read is still completed.
//   The ack is still pulsed to that owner; there is no abort.
// - Simultaneous requests: only rr_ptr order decides. Losers stay pending.
//   Worst-case wait is NUM_REQ-1 transactions.
// - New request arriving in the ack cycle: considered in the following IDLE cycle.
// - reset_n low mid-transaction: immediately IDLE, l2_read_o=0, any pending L2 read is abandoned.
//   L2 is also reset by the same reset_n.
//
// CONFIGURATION
// - L2_ARB_PERF_EN defined: adds outputs
//   - perf_grant_o   NUM_REQ*32  per-requester completed-transaction counts.
//   - perf_wait_o    NUM_REQ*32  per-requester cycles with req_read_i=1 and no grant to that port.
//   - Both counters reset to 0 and wrap at 2^32.
// - L2_ARB_PERF_EN undefined: those ports and counters do not exist; all other behaviour is identical.
//
// TESTING
// - Single req: req_read_i=01, addr0=0x0000123.
//   -> l2_read_o=1, l2_addr_o=0x0000123 next cycle.
//   -> L2 acks 3 cycles later with data=all 0xA5: req_ack_o=01 that cycle, req_data_o=0xA5.., l2_read_o=0 next cycle.
// - Contention: req_read_i=11 from reset.
//   -> port 0 served first, then port 1 after 1 bubble.
//   -> Hold both for 4 transactions: grant order 0,1,0,1.
// - Address stability: change addr0 to 0x3FFFFFF while BUSY -> l2_addr_o keeps 0x0000123 until ack.
// - Stray/late ack: pulse l2_ack_i in IDLE -> req_ack_o stays 00, no state change.
//   Ack in the same cycle port 1 raises req -> port 1 granted 1 cycle later.
// - Reset mid-op: drop reset_n while BUSY -> l2_read_o=0 and req_ack_o=0 asynchronously.
//   After release with req_read_i=10 -> port 1 granted (rr_ptr=0, first set bit).
// - L2_ARB_PERF_EN: 3 grants to port 0, port 1 waiting 5 cycles.
//   -> perf_grant_o[0]=3, perf_wait_o[1]=5.

Source files
------------

// File: rtl/l2_read_arbiter.sv
// Round-robin arbiter sharing one L2 line-read port among NUM_REQ L1 miss engines,
// one outstanding read at a time. Define L2_ARB_PERF_EN to add per-port grant/wait counters.
module l2_read_arbiter #(
   parameter int NUM_REQ    = 2,
   parameter int ADDR_WIDTH = 26,
   parameter int REQ_IDX_W  = 1
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic [NUM_REQ-1:0]              req_read_i,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr_i,
   output logic [NUM_REQ-1:0]              req_ack_o,
   output logic [511:0]                    req_data_o,
   output logic                            l2_read_o,
   output logic [ADDR_WIDTH-1:0]           l2_addr_o,
   input  logic                            l2_ack_i,
   input  logic [511:0]                    l2_data_i,
   output logic [REQ_IDX_W-1:0]            owner_o
`ifdef L2_ARB_PERF_EN
   ,
   output logic [NUM_REQ*32-1:0]           perf_grant_o,
   output logic [NUM_REQ*32-1:0]           perf_wait_o
`endif
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t                 state_q, state_d;
   logic [REQ_IDX_W-1:0]   owner_q, owner_d;
   logic [REQ_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

   logic                   win_valid;
   logic [REQ_IDX_W-1:0]   win_idx;
   logic [REQ_IDX_W:0]     scan_idx;
   logic [REQ_IDX_W-1:0]   owner_next;
   logic                   busy;
   logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];

   genvar gi;

   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_port
         assign addr_arr[gi]  = req_addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign req_ack_o[gi] = busy && l2_ack_i && (owner_q == REQ_IDX_W'(gi));
      end
   endgenerate

   assign busy       = (state_q == BUSY);
   assign l2_read_o  = busy;
   assign l2_addr_o  = addr_q;
   assign owner_o    = owner_q;
   assign req_data_o = l2_data_i;
   assign owner_next = (owner_q == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

   // First requester at or after rr_ptr, scanning with wrap-around.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = {1'b0, rr_ptr_q} + (REQ_IDX_W+1)'(k);
         if (scan_idx >= (REQ_IDX_W+1)'(NUM_REQ))
            scan_idx = scan_idx - (REQ_IDX_W+1)'(NUM_REQ);
         if (!win_valid && req_read_i[scan_idx[REQ_IDX_W-1:0]]) begin
            win_valid = 1'b1;
            win_idx   = scan_idx[REQ_IDX_W-1:0];
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      rr_ptr_d = rr_ptr_q;
      addr_d   = addr_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = BUSY;
               owner_d = win_idx;
               addr_d  = addr_arr[win_idx];
            end
         end
         BUSY: begin
            // Completion is taken even if the owner has withdrawn its request.
            if (l2_ack_i) begin
               state_d  = IDLE;
               rr_ptr_d = owner_next;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         owner_q  <= '0;
         rr_ptr_q <= '0;
         addr_q   <= '0;
      end else begin
         state_q  <= state_d;
         owner_q  <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         addr_q   <= addr_d;
      end
   end

`ifdef L2_ARB_PERF_EN
   generate
      for (gi = 0; gi < NUM_REQ; gi++) begin : g_perf
         logic [31:0] grant_q, grant_d;
         logic [31:0] wait_q, wait_d;

         // A port is waiting whenever it requests but is not the active owner.
         always_comb begin
            grant_d = grant_q;
            wait_d  = wait_q;
            if (req_ack_o[gi])
               grant_d = grant_q + 32'd1;
            if (req_read_i[gi] && !(busy && (owner_q == REQ_IDX_W'(gi))))
               wait_d = wait_q + 32'd1;
         end

         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               grant_q <= '0;
               wait_q  <= '0;
            end else begin
               grant_q <= grant_d;
               wait_q  <= wait_d;
            end
         end

         assign perf_grant_o[gi*32 +: 32] = grant_q;
         assign perf_wait_o[gi*32 +: 32]  = wait_q;
      end
   endgenerate
`endif

endmodule

// File: tb/tb_l2_read_arbiter.sv
// Directed bench for l2_read_arbiter: inputs driven and outputs sampled on the falling edge.
// Perf-counter scenario is compiled only when L2_ARB_PERF_EN is defined.
module tb_l2_read_arbiter;

   localparam int NUM_REQ    = 2;
   localparam int ADDR_WIDTH = 26;
   localparam int REQ_IDX_W  = 1;

   logic                          clk;
   logic                          reset_n;
   logic [NUM_REQ-1:0]            req_read_i;
   logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr_i;
   logic [NUM_REQ-1:0]            req_ack_o;
   logic [511:0]                  req_data_o;
   logic                          l2_read_o;
   logic [ADDR_WIDTH-1:0]         l2_addr_o;
   logic                          l2_ack_i;
   logic [511:0]                  l2_data_i;
   logic [REQ_IDX_W-1:0]          owner_o;
`ifdef L2_ARB_PERF_EN
   logic [NUM_REQ*32-1:0]         perf_grant_o;
   logic [NUM_REQ*32-1:0]         perf_wait_o;
`endif

   int vectors    = 0;
   int miscompares = 0;

   l2_read_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .ADDR_WIDTH (ADDR_WIDTH),
      .REQ_IDX_W  (REQ_IDX_W)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .req_read_i (req_read_i),
      .req_addr_i (req_addr_i),
      .req_ack_o  (req_ack_o),
      .req_data_o (req_data_o),
      .l2_read_o  (l2_read_o),
      .l2_addr_o  (l2_addr_o),
      .l2_ack_i   (l2_ack_i),
      .l2_data_i  (l2_data_i),
      .owner_o    (owner_o)
`ifdef L2_ARB_PERF_EN
      ,
      .perf_grant_o (perf_grant_o),
      .perf_wait_o  (perf_wait_o)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1, "watchdog");
   end

   task automatic do_reset();
      reset_n    = 1'b0;
      req_read_i = '0;
      req_addr_i = '0;
      l2_ack_i   = 1'b0;
      l2_data_i  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n    = 1'b0;
      req_read_i = 2'b11;
      req_addr_i = '1;
      l2_ack_i   = 1'b1;
      l2_data_i  = '0;
      repeat (2) @(negedge clk);
      #1;
      vectors++;
      if (l2_read_o !== 1'b0) begin miscompares++; $display("FAIL reset_l2_read: got %0b, want 0", l2_read_o); end
      vectors++;
      if (l2_addr_o !== '0) begin miscompares++; $display("FAIL reset_l2_addr: got %h, want 0", l2_addr_o); end
      vectors++;
      if (owner_o !== '0) begin miscompares++; $display("FAIL reset_owner: got %0d, want 0", owner_o); end
      vectors++;
      if (req_ack_o !== 2'b00) begin miscompares++; $display("FAIL reset_ack: got %b, want 00", req_ack_o); end
      $display("txn reset: l2_read=%0b addr=%h owner=%0d ack=%b", l2_read_o, l2_addr_o, owner_o, req_ack_o);
   endtask

   task automatic test_single();
      do_reset();
      @(negedge clk);
      req_read_i = 2'b01;
      req_addr_i[0 +: ADDR_WIDTH] = 26'h0000123;
      #1;
      vectors++;
      if (l2_read_o !== 1'b0) begin miscompares++; $display("FAIL single_latency: got l2_read=%0b, want 0", l2_read_o); end
      @(negedge clk);
      #1;
      vectors++;
      if (l2_read_o !== 1'b1) begin miscompares++; $display("FAIL single_grant: got l2_read=%0b, want 1", l2_read_o); end
      vectors++;
      if (l2_addr_o !== 26'h0000123) begin miscompares++; $display("FAIL single_addr: got %h, want 0000123", l2_addr_o); end
      vectors++;
      if (req_ack_o !== 2'b00) begin miscompares++; $display("FAIL single_early_ack: got %b, want 00", req_ack_o); end
      @(negedge clk);
      req_addr_i[0 +: ADDR_WIDTH] = 26'h3FFFFFF;
      #1;
      vectors++;
      if (l2_addr_o !== 26'h0000123) begin miscompares++; $display("FAIL addr_frozen: got %h, want 0000123", l2_addr_o); end
      @(negedge clk);
      @(negedge clk);
      l2_ack_i  = 1'b1;
      l2_data_i = {64{8'hA5}};
      #1;
      vectors++;
      if (req_ack_o !== 2'b01) begin miscompares++; $display("FAIL single_ack: got %b, want 01", req_ack_o); end
      vectors++;
      if (req_data_o !== {64{8'hA5}}) begin miscompares++; $display("FAIL single_data: got %h, want a5..a5", req_data_o[63:0]); end
      vectors++;
      if (l2_addr_o !== 26'h0000123) begin miscompares++; $display("FAIL addr_at_ack: got %h, want 0000123", l2_addr_o); end
      @(negedge clk);
      l2_ack_i   = 1'b0;
      req_read_i = 2'b00;
      #1;
      vectors++;
      if (l2_read_o !== 1'b0) begin miscompares++; $display("FAIL single_release: got l2_read=%0b, want 0", l2_read_o); end
      vectors++;
      if (req_ack_o !== 2'b00) begin miscompares++; $display("FAIL single_ack_drop: got %b, want 00", req_ack_o); end
      $display("txn single: owner=%0d addr=%h", owner_o, l2_addr_o);
   endtask

   task automatic test_contention();
      logic [REQ_IDX_W-1:0] exp_owner;
      logic [NUM_REQ-1:0]   exp_ack;
      int n;
      do_reset();
      @(negedge clk);
      req_read_i = 2'b11;
      req_addr_i[0 +: ADDR_WIDTH]          = 26'h0000AAA;
      req_addr_i[ADDR_WIDTH +: ADDR_WIDTH] = 26'h0000BBB;
      for (int t = 0; t < 4; t++) begin
         exp_owner = REQ_IDX_W'(t % 2);
         exp_ack   = 2'b01 << exp_owner;
         n = 0;
         while (l2_read_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
         end
         #1;
         vectors++;
         if (l2_read_o !== 1'b1 || owner_o !== exp_owner) begin
            miscompares++;
            $display("FAIL rr_owner_%0d: got read=%0b owner=%0d, want read=1 owner=%0d", t, l2_read_o, owner_o, exp_owner);
         end
         vectors++;
         if (l2_addr_o !== ((exp_owner == 0) ? 26'h0000AAA : 26'h0000BBB)) begin
            miscompares++;
            $display("FAIL rr_addr_%0d: got %h, want owner %0d address", t, l2_addr_o, exp_owner);
         end
         l2_ack_i = 1'b1;
         #1;
         vectors++;
         if (req_ack_o !== exp_ack) begin miscompares++; $display("FAIL rr_ack_%0d: got %b, want %b", t, req_ack_o, exp_ack); end
         @(negedge clk);
         l2_ack_i = 1'b0;
         #1;
         vectors++;
         if (l2_read_o !== 1'b0) begin miscompares++; $display("FAIL rr_bubble_%0d: got l2_read=%0b, want 0", t, l2_read_o); end
         $display("txn contention %0d: owner=%0d ack=%b", t, exp_owner, exp_ack);
      end
      req_read_i = 2'b00;
   endtask

   task automatic test_owner_drop();
      do_reset();
      @(negedge clk);
      req_read_i = 2'b01;
      @(negedge clk);
      req_read_i = 2'b00;
      @(negedge clk);
      l2_ack_i = 1'b1;
      #1;
      vectors++;
      if (req_ack_o !== 2'b01) begin miscompares++; $display("FAIL drop_ack: got %b, want 01", req_ack_o); end
      @(negedge clk);
      l2_ack_i = 1'b0;
      $display("txn owner_drop: ack delivered to withdrawn owner");
   endtask

   task automatic test_stray_ack();
      do_reset();
      @(negedge clk);
      l2_ack_i = 1'b1;
      #1;
      vectors++;
      if (req_ack_o !== 2'b00) begin miscompares++; $display("FAIL stray_ack: got %b, want 00", req_ack_o); end
      @(negedge clk);
      #1;
      vectors++;
      if (l2_read_o !== 1'b0) begin miscompares++; $display("FAIL stray_state: got l2_read=%0b, want 0", l2_read_o); end
      req_read_i = 2'b10;
      #1;
      vectors++;
      if (req_ack_o !== 2'b00) begin miscompares++; $display("FAIL stray_ack_req: got %b, want 00", req_ack_o); end
      @(negedge clk);
      l2_ack_i = 1'b0;
      #1;
      vectors++;
      if (l2_read_o !== 1'b1 || owner_o !== 1'b1) begin
         miscompares++;
         $display("FAIL stray_grant: got read=%0b owner=%0d, want read=1 owner=1", l2_read_o, owner_o);
      end
      @(negedge clk);
      l2_ack_i = 1'b1;
      @(negedge clk);
      l2_ack_i   = 1'b0;
      req_read_i = 2'b00;
      $display("txn stray_ack: port 1 granted after ignored ack");
   endtask

   task automatic test_reset_mid_op();
      do_reset();
      @(negedge clk);
      req_read_i = 2'b10;
      req_addr_i[ADDR_WIDTH +: ADDR_WIDTH] = 26'h1234567;
      @(negedge clk);
      #1;
      vectors++;
      if (l2_read_o !== 1'b1 || owner_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_pre: got read=%0b owner=%0d, want read=1 owner=1", l2_read_o, owner_o);
      end
      l2_ack_i = 1'b1;
      reset_n  = 1'b0;
      #1;
      vectors++;
      if (l2_read_o !== 1'b0) begin miscompares++; $display("FAIL midrst_read: got %0b, want 0", l2_read_o); end
      vectors++;
      if (req_ack_o !== 2'b00) begin miscompares++; $display("FAIL midrst_ack: got %b, want 00", req_ack_o); end
      vectors++;
      if (owner_o !== 1'b0 || l2_addr_o !== '0) begin
         miscompares++;
         $display("FAIL midrst_regs: got owner=%0d addr=%h, want owner=0 addr=0", owner_o, l2_addr_o);
      end
      @(negedge clk);
      reset_n    = 1'b1;
      l2_ack_i   = 1'b0;
      req_read_i = 2'b10;
      @(negedge clk);
      #1;
      vectors++;
      if (l2_read_o !== 1'b1 || owner_o !== 1'b1) begin
         miscompares++;
         $display("FAIL midrst_regrant: got read=%0b owner=%0d, want read=1 owner=1", l2_read_o, owner_o);
      end
      l2_ack_i = 1'b1;
      @(negedge clk);
      l2_ack_i   = 1'b0;
      req_read_i = 2'b00;
      $display("txn reset_mid_op: abandoned read, port 1 regranted");
   endtask

`ifdef L2_ARB_PERF_EN
   task automatic test_perf();
      int n;
      do_reset();
      for (int t = 0; t < 3; t++) begin
         @(negedge clk);
         req_read_i = 2'b01;
         n = 0;
         while (l2_read_o !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
         end
         if (t == 2) begin
            req_read_i = 2'b11;
            repeat (5) @(negedge clk);
            req_read_i = 2'b01;
         end
         l2_ack_i = 1'b1;
         @(negedge clk);
         l2_ack_i   = 1'b0;
         req_read_i = 2'b00;
      end
      #1;
      vectors++;
      if (perf_grant_o[31:0] !== 32'd3) begin miscompares++; $display("FAIL perf_grant0: got %0d, want 3", perf_grant_o[31:0]); end
      vectors++;
      if (perf_wait_o[63:32] !== 32'd5) begin miscompares++; $display("FAIL perf_wait1: got %0d, want 5", perf_wait_o[63:32]); end
      vectors++;
      if (perf_grant_o[63:32] !== 32'd0) begin miscompares++; $display("FAIL perf_grant1: got %0d, want 0", perf_grant_o[63:32]); end
      $display("txn perf: grant0=%0d wait1=%0d", perf_grant_o[31:0], perf_wait_o[63:32]);
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_owner_drop();
      test_stray_ack();
      test_reset_mid_op();
`ifdef L2_ARB_PERF_EN
      test_perf();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
